fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage of the five-stage pipeline. It keeps the program counter, issues instruction reads to the bus interface with at most one request outstanding, and buffers returned words in a small prefetch FIFO so fetching continues while decode is stalled. It presents the oldest buffered instruction to decode and obeys the stall signal from the hazard unit. On a redirect from branch, trap or mret resolution, it flushes the buffer and discards any in-flight response.

## Interface
Parameters:
- RESET_VECTOR, 32'h0000_0000, first fetch address after reset.
- FIFO_DEPTH, 2, prefetch entries; legal values are 2 and 4.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low; low forces the reset state immediately.
- fetch_request  out  1  read request to the bus interface.
- fetch_address  out  32  word address of the request.
- fetch_ready  in  1  one-cycle completion pulse; fetch_data is valid with it.
- fetch_data  in  32  returned instruction word.
- stall  in  1  decode cannot accept this cycle.
- redirect_valid  in  1  control-flow change from branch, trap or mret.
- redirect_address  in  32  new PC.
- valid_decode  out  1  the instruction outputs are meaningful.
- pc_decode  out  32  PC of the presented instruction.
- next_pc_decode  out  32  pc_decode + 4, modulo 2^32.
- instruction_decode  out  32  presented instruction word.

## Operation
- FIFO entry contents: {pc, instruction}. The head drives the *_decode outputs combinationally from registers.
- valid_decode is 1 when the FIFO is non-empty.
- Pop: the head is removed at the edge where valid_decode=1 and stall=0.
- State machine:
  - IDLE: no request.
  - WAIT: a request is outstanding.
  - DROP: a request is outstanding and its response will be discarded.
- IDLE to WAIT: when FIFO occupancy after this edge's pop is less than FIFO_DEPTH. The request is raised in the cycle following the edge.
- WAIT: fetch_request=1 and fetch_address=pc, both held stable until fetch_ready.
  - On fetch_ready: push {pc, fetch_data} and set pc to pc+4.
  - Then stay in WAIT if space remains after this cycle's push and pop; otherwise go to IDLE.
- fetch_request and fetch_address are not withdrawn or changed while in WAIT or DROP. This holds even if a redirect occurs.
- redirect_valid=1 has priority over stall and pop:
  - The FIFO is cleared and pc is set to redirect_address.
  - If a request was outstanding and fetch_ready=0 that cycle, go to DROP.
  - Otherwise go to WAIT with the new pc.
- DROP: fetch_request stays high with the old address. On fetch_ready the data is discarded and the next state is WAIT at the redirected pc.
- A second redirect during DROP only updates pc.
- redirect_address[1:0] handling is set by the configuration macro.

## Timing
- Reset values:
  - fetch_request=0, fetch_address=RESET_VECTOR.
  - valid_decode=0, pc_decode=0, next_pc_decode=4, instruction_decode=0.
  - FIFO empty, state IDLE, pc=RESET_VECTOR.
- First request: fetch_request rises in the first cycle after the first rising edge with reset high.
- The bus may assert fetch_ready in the same cycle the request is raised. This gives a sustained rate of 1 instruction per cycle when decode never stalls.
- Response latency: a response pushed at edge N is visible as valid_decode=1 in cycle N+1. There is no bypass.
- Simultaneous push and pop with a full FIFO is legal. Occupancy is unchanged.
- A redirect in the same cycle as fetch_ready discards that data. Nothing is pushed.
- Reset asserted mid-request: state returns to IDLE immediately. Any bus completion arriving later is ignored, because the bus interface is reset by the same signal.
- PC arithmetic wraps: 32'hFFFF_FFFC + 4 = 0.

## Configuration
- FETCH_MISALIGN_TRAP_EN defined:
  - Adds output misaligned_decode (1 bit, reset 0).
  - A redirect with redirect_address[1:0] != 0 issues no bus request. It pushes one entry {redirect_address, 32'h0000_0013} with misaligned_decode=1.
  - The unit then stays in IDLE until the next redirect.
- FETCH_MISALIGN_TRAP_EN undefined: redirect_address[1:0] is forced to 2'b00, and the port and flag do not exist.

## Test plan
- Reset release with RESET_VECTOR=32'h100 and a zero-wait bus:
  - Required: requests to 0x100, 0x104 and 0x108 on consecutive cycles.
  - Required: valid_decode rises one cycle after the first fetch_ready, with pc_decode=0x100 and next_pc_decode=0x104.
- Hold stall=1 with FIFO_DEPTH=2:
  - Required: exactly 2 words are buffered, then fetch_request drops.
  - Deassert stall: outputs drain in order 0x100, 0x104, and fetching resumes at 0x108.
- Redirect to 0x200 while a 3-cycle bus request to 0x10C is outstanding:
  - Required: address 0x10C is held until completion and its data is discarded.
  - Required: the next request is 0x200, and the first valid_decode shows pc_decode=0x200.
- Redirect in the same cycle as fetch_ready and a pop:
  - Required: the FIFO ends empty, the returned word is absent, and the next request goes to redirect_address.
- Assert reset (low) while in WAIT:
  - Required: fetch_request=0 and valid_decode=0 immediately, before the next clock edge.
- Redirect to 0x202 with FETCH_MISALIGN_TRAP_EN defined:
  - Required: no bus request.
  - Required: one entry with pc_decode=0x202, instruction_decode=0x13 and misaligned_decode=1.
  - Without the macro, the next request goes to 0x200.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit -- instruction fetch stage.
//
// Holds the fetch PC and keeps at most one bus read outstanding. Returned words go into a
// small prefetch FIFO, so fetching continues while decode is stalled. The oldest buffered
// entry is shown to decode.
//
// A redirect (branch, trap or mret) does three things: it clears the FIFO, loads the new PC,
// and discards any response that is still in flight. The bus request itself is never withdrawn.
//
// Optional feature macro: FETCH_MISALIGN_TRAP_EN.
//   Defined   : a misaligned redirect target makes no bus request. Instead one marker entry
//               {target, 32'h13} is pushed with misaligned_decode=1, and fetching halts until
//               the next redirect.
//   Undefined : redirect_address[1:0] is forced to zero.
//
// Ports:
//   clk, reset            clock; asynchronous active-low reset
//   fetch_request/address read request to the bus interface (held until fetch_ready)
//   fetch_ready/data      one-cycle completion pulse with the returned word
//   stall                 decode cannot accept this cycle
//   redirect_valid/addr   control-flow change and new PC
//   valid_decode, pc_decode, next_pc_decode, instruction_decode  FIFO head to decode
//   misaligned_decode     (macro only) head entry is a misaligned-target marker
module fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH   = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        fetch_request,
  output logic [31:0] fetch_address,
  input  logic        fetch_ready,
  input  logic [31:0] fetch_data,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_address,
  output logic        valid_decode,
  output logic [31:0] pc_decode,
  output logic [31:0] next_pc_decode,
  output logic [31:0] instruction_decode
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic        misaligned_decode
`endif
);

  // FIFO_DEPTH is 2 or 4, so the pointers wrap naturally.
  localparam int unsigned PW = (FIFO_DEPTH > 2) ? 2 : 1;
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] DepthC = CW'(FIFO_DEPTH);
  localparam logic [31:0] NopInstr = 32'h0000_0013;

  typedef enum logic [1:0] {StIdle, StWait, StDrop} state_e;

  state_e        r_state;
  logic [31:0]   r_pc;
  logic [31:0]   r_drop_addr;
  logic [31:0]   r_fifo_pc    [FIFO_DEPTH];
  logic [31:0]   r_fifo_instr [FIFO_DEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic [FIFO_DEPTH-1:0] r_fifo_mis;
  logic                  r_halt;
`endif

  logic          w_outstanding;
  logic          w_pop;
  logic          w_push;
  logic          w_halt;
  logic          w_redir_mis;
  logic [31:0]   w_redir_pc;
  logic [CW-1:0] w_count_after_pop;
  logic [CW-1:0] w_count_next;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign w_halt      = r_halt;
  assign w_redir_mis = |redirect_address[1:0];
  assign w_redir_pc  = redirect_address;
`else
  assign w_halt      = 1'b0;
  assign w_redir_mis = 1'b0;
  assign w_redir_pc  = redirect_address & 32'hFFFF_FFFC;
`endif

  // Decode side: the FIFO head is shown directly from the storage registers.
  assign valid_decode       = (r_count != '0);
  assign pc_decode          = r_fifo_pc[r_head];
  assign next_pc_decode     = pc_decode + 32'd4;
  assign instruction_decode = r_fifo_instr[r_head];
`ifdef FETCH_MISALIGN_TRAP_EN
  assign misaligned_decode  = valid_decode & r_fifo_mis[r_head];
`endif

  // Bus side: in DROP the stale address stays on the bus until its response arrives.
  assign w_outstanding = (r_state != StIdle);
  assign fetch_request = w_outstanding;
  assign fetch_address = (r_state == StDrop) ? r_drop_addr : r_pc;

  // A redirect overrides both the pop and the push in the same cycle.
  assign w_pop  = valid_decode & ~stall & ~redirect_valid;
  assign w_push = (r_state == StWait) & fetch_ready & ~redirect_valid;

  assign w_count_after_pop = r_count - {{(CW-1){1'b0}}, w_pop};
  assign w_count_next      = w_count_after_pop + {{(CW-1){1'b0}}, w_push};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= StIdle;
      r_pc        <= RESET_VECTOR;
      r_drop_addr <= RESET_VECTOR;
      r_head      <= '0;
      r_tail      <= '0;
      r_count     <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_fifo_pc[i]    <= '0;
        r_fifo_instr[i] <= '0;
      end
`ifdef FETCH_MISALIGN_TRAP_EN
      r_fifo_mis <= '0;
      r_halt     <= 1'b0;
`endif
    end else if (redirect_valid) begin
      r_pc    <= w_redir_pc;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      if (w_outstanding && !fetch_ready) begin
        // The old response is still coming; its address stays on the bus until it lands.
        r_state <= StDrop;
        if (r_state == StWait) begin
          r_drop_addr <= r_pc;
        end
      end else begin
        r_state <= StWait;
      end
`ifdef FETCH_MISALIGN_TRAP_EN
      r_halt <= w_redir_mis;
      if (w_redir_mis) begin
        r_fifo_pc[0]    <= redirect_address;
        r_fifo_instr[0] <= NopInstr;
        r_fifo_mis[0]   <= 1'b1;
        r_tail          <= PW'(1);
        r_count         <= CW'(1);
        if (!(w_outstanding && !fetch_ready)) begin
          r_state <= StIdle;
        end
      end
`endif
    end else begin
      r_count <= w_count_next;
      if (w_push) begin
        r_fifo_pc[r_tail]    <= r_pc;
        r_fifo_instr[r_tail] <= fetch_data;
`ifdef FETCH_MISALIGN_TRAP_EN
        r_fifo_mis[r_tail]   <= 1'b0;
`endif
        r_tail               <= r_tail + PW'(1);
      end
      if (w_pop) begin
        r_head <= r_head + PW'(1);
      end

      unique case (r_state)
        StIdle: begin
          if ((w_count_after_pop < DepthC) && !w_halt) begin
            r_state <= StWait;
          end
        end
        StWait: begin
          if (fetch_ready) begin
            r_pc <= r_pc + 32'd4;
            if (w_count_next >= DepthC) begin
              r_state <= StIdle;
            end
          end
        end
        StDrop: begin
          if (fetch_ready) begin
            r_state <= w_halt ? StIdle : StWait;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // The opcode constant is only referenced by the optional feature.
  logic w_unused;
  assign w_unused = ^{NopInstr, w_redir_mis};

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit (RESET_VECTOR=0x100, FIFO_DEPTH=2).
module tb_fetch_unit;

  localparam logic [31:0] RV    = 32'h0000_0100;
  localparam int unsigned DEPTH = 2;

  logic        clk;
  logic        reset;
  logic        fetch_request;
  logic [31:0] fetch_address;
  logic        fetch_ready;
  logic [31:0] fetch_data;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_address;
  logic        valid_decode;
  logic [31:0] pc_decode;
  logic [31:0] next_pc_decode;
  logic [31:0] instruction_decode;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        misaligned_decode;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // Bus model controls.
  bit          bus_rand  = 1'b0;
  int          bus_lat   = 0;
  logic [31:0] slow_addr = 32'hFFFF_FFFF;
  int          slow_lat  = 0;

  fetch_unit #(
    .RESET_VECTOR(RV),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .fetch_request     (fetch_request),
    .fetch_address     (fetch_address),
    .fetch_ready       (fetch_ready),
    .fetch_data        (fetch_data),
    .stall             (stall),
    .redirect_valid    (redirect_valid),
    .redirect_address  (redirect_address),
    .valid_decode      (valid_decode),
    .pc_decode         (pc_decode),
    .next_pc_decode    (next_pc_decode),
    .instruction_decode(instruction_decode)
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    .misaligned_decode (misaligned_decode)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // The word stored at each address of the instruction memory.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_0F13;
  endfunction

  // Bus responder. It drives fetch_ready/fetch_data at the negedge for the next posedge,
  // and checks that an unanswered request is neither withdrawn nor changed.
  initial begin : bus
    int          cnt;
    int          cur_lat;
    bit          pend;
    logic [31:0] pend_addr;
    cnt = 0; cur_lat = 0; pend = 1'b0; pend_addr = '0;
    fetch_ready = 1'b0;
    fetch_data  = '0;
    forever begin
      @(negedge clk);
      if (pend && reset) begin
        n_checks++;
        if (fetch_request !== 1'b1 || fetch_address !== pend_addr) begin
          n_errors++;
          $display("FAIL bus_hold: req=%b addr=%h, required req=1 addr=%h",
                   fetch_request, fetch_address, pend_addr);
        end
      end
      if (reset && fetch_request) begin
        if (cnt == 0) begin
          cur_lat = bus_rand ? int'($urandom_range(0, 3)) :
                    ((fetch_address == slow_addr) ? slow_lat : bus_lat);
        end
        if (cnt >= cur_lat) begin
          fetch_ready = 1'b1;
          fetch_data  = mem_word(fetch_address);
          cnt  = 0;
          pend = 1'b0;
        end else begin
          fetch_ready = 1'b0;
          cnt++;
          pend      = 1'b1;
          pend_addr = fetch_address;
        end
      end else begin
        fetch_ready = 1'b0;
        cnt  = 0;
        pend = 1'b0;
      end
    end
  end

  // Applies reset and releases it at a negedge; the next negedge is cycle 1.
  task automatic do_reset();
    reset            = 1'b0;
    stall            = 1'b0;
    redirect_valid   = 1'b0;
    redirect_address = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset            = 1'b0;
    stall            = 1'b0;
    redirect_valid   = 1'b0;
    redirect_address = '0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({fetch_request, valid_decode} !== 2'b00) begin
      n_errors++;
      $display("FAIL reset_flags: req=%b valid=%b, required 0 0", fetch_request, valid_decode);
    end
    n_checks++;
    if (fetch_address !== RV) begin
      n_errors++;
      $display("FAIL reset_addr: got %h, required %h", fetch_address, RV);
    end
    n_checks++;
    if (pc_decode !== 32'h0 || next_pc_decode !== 32'h4 || instruction_decode !== 32'h0) begin
      n_errors++;
      $display("FAIL reset_decode: pc=%h next=%h instr=%h, required 0 4 0",
               pc_decode, next_pc_decode, instruction_decode);
    end
  endtask

  task automatic test_startup();
    bus_lat = 0;
    do_reset();
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      n_checks++;
      if (fetch_request !== 1'b1 || fetch_address !== RV + 32'(4 * (k - 1))) begin
        n_errors++;
        $display("FAIL startup_req%0d: req=%b addr=%h, required 1 %h", k, fetch_request,
                 fetch_address, RV + 32'(4 * (k - 1)));
      end
      n_checks++;
      if (k == 1 && valid_decode !== 1'b0) begin
        n_errors++;
        $display("FAIL startup_nobypass: valid=%b, required 0", valid_decode);
      end else if (k > 1 && (valid_decode !== 1'b1 || pc_decode !== RV + 32'(4 * (k - 2)) ||
                             next_pc_decode !== RV + 32'(4 * (k - 1)) ||
                             instruction_decode !== mem_word(RV + 32'(4 * (k - 2))))) begin
        n_errors++;
        $display("FAIL startup_dec%0d: valid=%b pc=%h next=%h instr=%h, required pc %h", k,
                 valid_decode, pc_decode, next_pc_decode, instruction_decode,
                 RV + 32'(4 * (k - 2)));
      end
    end
  endtask

  task automatic test_stall();
    bus_lat = 0;
    do_reset();
    stall = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (fetch_request !== 1'b1 || fetch_address !== 32'h104) begin
      n_errors++;
      $display("FAIL stall_second_req: req=%b addr=%h, required 1 00000104",
               fetch_request, fetch_address);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks++;
      if (fetch_request !== 1'b0 || valid_decode !== 1'b1 || pc_decode !== 32'h100) begin
        n_errors++;
        $display("FAIL stall_full%0d: req=%b valid=%b pc=%h, required 0 1 00000100", k,
                 fetch_request, valid_decode, pc_decode);
      end
    end
    stall = 1'b0;
    @(negedge clk);
    n_checks++;
    if (pc_decode !== 32'h104 || fetch_request !== 1'b1 || fetch_address !== 32'h108) begin
      n_errors++;
      $display("FAIL stall_drain: pc=%h req=%b addr=%h, required 00000104 1 00000108",
               pc_decode, fetch_request, fetch_address);
    end
    @(negedge clk);
    n_checks++;
    if (valid_decode !== 1'b1 || pc_decode !== 32'h108) begin
      n_errors++;
      $display("FAIL stall_resume: valid=%b pc=%h, required 1 00000108", valid_decode, pc_decode);
    end
  endtask

  task automatic test_redirect_drop();
    bit found;
    int held;
    bus_lat   = 0;
    slow_addr = 32'h10C;
    slow_lat  = 2;
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (fetch_request === 1'b1 && fetch_address === 32'h10C) found = 1'b1;
    end
    n_checks++;
    if (!found) begin
      n_errors++;
      $display("FAIL drop_reach: request to 0000010c not seen, required within 20 cycles");
    end
    redirect_valid   = 1'b1;
    redirect_address = 32'h200;
    @(negedge clk);
    redirect_valid = 1'b0;
    held = 0;
    while (held < 10 && fetch_request === 1'b1 && fetch_address === 32'h10C) begin
      n_checks++;
      if (valid_decode !== 1'b0) begin
        n_errors++;
        $display("FAIL drop_empty: valid=%b, required 0", valid_decode);
      end
      held++;
      @(negedge clk);
    end
    n_checks++;
    if (held != 2) begin
      n_errors++;
      $display("FAIL drop_hold: old address held %0d cycles, required 2", held);
    end
    n_checks++;
    if (fetch_request !== 1'b1 || fetch_address !== 32'h200 || valid_decode !== 1'b0) begin
      n_errors++;
      $display("FAIL drop_next: req=%b addr=%h valid=%b, required 1 00000200 0",
               fetch_request, fetch_address, valid_decode);
    end
    @(negedge clk);
    n_checks++;
    if (valid_decode !== 1'b1 || pc_decode !== 32'h200 || instruction_decode !== mem_word(32'h200)) begin
      n_errors++;
      $display("FAIL drop_first: valid=%b pc=%h instr=%h, required 1 00000200 %h",
               valid_decode, pc_decode, instruction_decode, mem_word(32'h200));
    end
    slow_addr = 32'hFFFF_FFFF;
  endtask

  task automatic test_redirect_ready_pop();
    bus_lat = 0;
    do_reset();
    repeat (3) @(negedge clk);
    n_checks++;
    if (valid_decode !== 1'b1 || fetch_request !== 1'b1 || fetch_address !== 32'h108) begin
      n_errors++;
      $display("FAIL rrp_setup: valid=%b req=%b addr=%h, required 1 1 00000108",
               valid_decode, fetch_request, fetch_address);
    end
    redirect_valid   = 1'b1;
    redirect_address = 32'h300;
    @(negedge clk);
    redirect_valid = 1'b0;
    n_checks++;
    if (valid_decode !== 1'b0 || fetch_request !== 1'b1 || fetch_address !== 32'h300) begin
      n_errors++;
      $display("FAIL rrp_flush: valid=%b req=%b addr=%h, required 0 1 00000300",
               valid_decode, fetch_request, fetch_address);
    end
    @(negedge clk);
    n_checks++;
    if (valid_decode !== 1'b1 || pc_decode !== 32'h300) begin
      n_errors++;
      $display("FAIL rrp_first: valid=%b pc=%h, required 1 00000300", valid_decode, pc_decode);
    end
  endtask

  task automatic test_async_reset();
    bus_lat = 0;
    do_reset();
    repeat (2) @(negedge clk);
    n_checks++;
    if (fetch_request !== 1'b1 || valid_decode !== 1'b1) begin
      n_errors++;
      $display("FAIL areset_setup: req=%b valid=%b, required 1 1", fetch_request, valid_decode);
    end
    #1 reset = 1'b0;
    #1;
    n_checks++;
    if (fetch_request !== 1'b0 || valid_decode !== 1'b0 || fetch_address !== RV) begin
      n_errors++;
      $display("FAIL areset_immediate: req=%b valid=%b addr=%h, required 0 0 %h",
               fetch_request, valid_decode, fetch_address, RV);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_misalign();
    bus_lat = 0;
    do_reset();
    repeat (2) @(negedge clk);
    redirect_valid   = 1'b1;
    redirect_address = 32'h202;
    @(negedge clk);
    redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
    n_checks++;
    if (fetch_request !== 1'b0 || valid_decode !== 1'b1 || pc_decode !== 32'h202 ||
        instruction_decode !== 32'h13 || misaligned_decode !== 1'b1) begin
      n_errors++;
      $display("FAIL mis_entry: req=%b valid=%b pc=%h instr=%h mis=%b, required 0 1 202 13 1",
               fetch_request, valid_decode, pc_decode, instruction_decode, misaligned_decode);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_checks++;
      if (fetch_request !== 1'b0 || valid_decode !== 1'b0 || misaligned_decode !== 1'b0) begin
        n_errors++;
        $display("FAIL mis_halt%0d: req=%b valid=%b mis=%b, required 0 0 0", k,
                 fetch_request, valid_decode, misaligned_decode);
      end
    end
`else
    n_checks++;
    if (fetch_request !== 1'b1 || fetch_address !== 32'h200) begin
      n_errors++;
      $display("FAIL align_req: req=%b addr=%h, required 1 00000200", fetch_request, fetch_address);
    end
    @(negedge clk);
    n_checks++;
    if (valid_decode !== 1'b1 || pc_decode !== 32'h200) begin
      n_errors++;
      $display("FAIL align_dec: valid=%b pc=%h, required 1 00000200", valid_decode, pc_decode);
    end
`endif
  endtask

  // Random stall/redirect/latency traffic. The decode stream must be consecutive words
  // starting at the reset vector or at the latest redirect target.
  task automatic test_random();
    logic [31:0] exp_pc;
    logic [31:0] ra;
    bit          st;
    bit          rd;
    int          pops;
    bus_rand = 1'b1;
    do_reset();
    exp_pc = RV;
    pops   = 0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      st = ($urandom_range(0, 9) < 3);
      rd = ($urandom_range(0, 24) == 0);
      ra = $urandom;
      if ($urandom_range(0, 3) == 0) ra = 32'hFFFF_FFF0 | (ra & 32'hF);
`ifdef FETCH_MISALIGN_TRAP_EN
      ra = ra & 32'hFFFF_FFFC;
`endif
      stall            = st;
      redirect_valid   = rd;
      redirect_address = ra;
      if (rd) begin
        exp_pc = ra & 32'hFFFF_FFFC;
      end else if (valid_decode === 1'b1 && !st) begin
        n_checks++;
        if (pc_decode !== exp_pc || next_pc_decode !== exp_pc + 32'd4 ||
            instruction_decode !== mem_word(exp_pc)) begin
          n_errors++;
          $display("FAIL rand_pop@%0d: pc=%h next=%h instr=%h, required %h %h %h", c,
                   pc_decode, next_pc_decode, instruction_decode, exp_pc, exp_pc + 32'd4,
                   mem_word(exp_pc));
        end
        exp_pc = exp_pc + 32'd4;
        pops++;
      end
    end
    @(negedge clk);
    stall          = 1'b0;
    redirect_valid = 1'b0;
    bus_rand       = 1'b0;
    n_checks++;
    if (pops < 500) begin
      n_errors++;
      $display("FAIL rand_progress: %0d instructions delivered, required at least 500", pops);
    end
  endtask

  initial begin
    test_reset();
    test_startup();
    test_stall();
    test_redirect_drop();
    test_redirect_ready_pop();
    test_async_reset();
    test_misalign();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
